wupr_refresh_scheduler: RTL and testbench
=========================================

Name: wupr_refresh_scheduler

Overview:
Sequences the WUPR write-tracking filter for the refresh path.
- A tREFI timer accrues refresh debt.
- For each owed refresh, the block queries WUPR with the current refresh row.
- If WUPR returns dref=1, the refresh is skipped as a dummy. Otherwise a real refresh request is handed to the command scheduler.
- The block also multiplexes incoming write-row updates onto the single WUPR Ra/Rt_write port, with writes taking priority.

Parameters:
ROW_WIDTH, 16, row address width (matches WUPR)
N, 16, WUPR segment count; N_BITS = $clog2(N)
T_REFI, 3900, clock cycles per refresh interval
ROWS_PER_REF, 8, row-pointer increment per refresh slot (power of two)
MAX_DEBT, 8, maximum postponed refreshes; DEBT_W = $clog2(MAX_DEBT+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
wr_valid  in  1  a row was written this cycle
wr_row  in  ROW_WIDTH  row address of the write
wupr_rt_write  out  1  to WUPR Rt_write
wupr_to_refresh  out  1  to WUPR to_refresh (refresh query strobe)
wupr_ra  out  ROW_WIDTH  to WUPR Ra
wupr_dref  in  1  WUPR dummy-refresh verdict, valid 1 cycle after the query
ref_req  out  1  real refresh request to the command scheduler
ref_row  out  ROW_WIDTH  row of the pending refresh; stable while ref_req=1
ref_grant  in  1  command scheduler accepts the refresh
ref_urgent  out  1  debt == MAX_DEBT; the command scheduler must stall new traffic
debt  out  DEBT_W  current owed refreshes
skip_cnt  out  16  saturating count of dummy-skipped refreshes

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM=IDLE, timer=0, row pointer ptr=0, debt=0, skip_cnt=0.
- Timer:
  - Counts 0..T_REFI-1. On reaching T_REFI-1 it wraps to 0 and raises tick for one cycle.
  - A tick increments debt, saturating at MAX_DEBT. The timer never stalls.
- WUPR port mux:
  - If wr_valid=1: wupr_rt_write=1, wupr_ra=wr_row, wupr_to_refresh=0, regardless of FSM state.
  - Otherwise wupr_ra=ptr, and wupr_to_refresh is driven by the FSM.
  - Outputs are combinational from registered FSM state plus the wr_valid input.
- FSM states:
  - IDLE: if debt>0, go to QUERY.
  - QUERY: assert wupr_to_refresh=1, wupr_ra=ptr.
    - If wr_valid=1 this cycle, the query is blocked and the FSM stays in QUERY.
    - Otherwise go to CHECK next cycle.
  - CHECK: sample wupr_dref.
    - dref=1: go to ADVANCE; skip_cnt++ (saturating at 0xFFFF).
    - dref=0: go to REQ, latching ref_row=ptr.
  - REQ: hold ref_req=1 with stable ref_row until ref_grant=1. On the grant cycle go to ADVANCE. ref_req drops the cycle after the grant.
  - ADVANCE: ptr += ROWS_PER_REF (mod 2^ROW_WIDTH); debt-- ; go to IDLE.
- Simultaneous events:
  - A tick and the ADVANCE decrement in the same cycle leave debt unchanged, with saturation applied after the net change.
  - A grant while ref_req=0 is ignored.
- Boundaries:
  - The ptr wrap from 0xFFF8 returns to 0x0000.
  - ref_urgent=1 iff debt==MAX_DEBT. Further ticks at MAX_DEBT are dropped, and the internal flag overflow_sticky is set (cleared only by reset).
- Reset mid-operation: an outstanding ref_req drops asynchronously, and the pending refresh is lost.
- Throughput: a dummy refresh takes 4 cycles IDLE→IDLE. A real refresh takes 4 cycles plus the grant wait.

Decomposition:
- Package wupr_pkg:
  - ROW_WIDTH, N, T_REFI and ROWS_PER_REF constants.
  - The typedef enum logic [2:0] {IDLE, QUERY, CHECK, REQ, ADVANCE} ref_state_e.
  - The typedef row_t.
- Sub-module refi_timer: counter plus one-cycle tick, parameterised by T_REFI.
- Everything else stays in wupr_refresh_scheduler.

Test Plan:
1. Reset, then run T_REFI cycles with no writes.
   - Expected: debt=1 at cycle 3900.
   - QUERY: wupr_ra=0x0000.
   - Bench WUPR model returns dref=0, so ref_req=1 with ref_row=0x0000.
   - After grant: ptr=0x0008, debt=0.
2. Bench model returns dref=1 on the second query.
   - Expected: no ref_req, skip_cnt=1, ptr=0x0010, 4-cycle turnaround.
3. Hold wr_valid=1 with wr_row=0x300A for 5 cycles while the FSM is in QUERY.
   - Expected: wupr_rt_write=1, wupr_ra=0x300A, wupr_to_refresh=0 throughout.
   - The query issues on the first cycle after wr_valid falls.
4. Tie ref_grant=0 for 9×T_REFI cycles.
   - Expected: debt saturates at 8 and ref_urgent=1.
   - Release the grant: 8 refreshes drain, then ref_urgent=0 after the first drain.
5. Preload ptr near wrap (run 8191 refreshes, or force ptr=0xFFF8).
   - Expected: the next ADVANCE gives ptr=0x0000.
6. Assert rst during REQ.
   - Expected: ref_req=0 in the same cycle, debt=0, FSM=IDLE.
   - Normal operation resumes after rst falls.

Source files
------------

// File: rtl/wupr_pkg.sv
// wupr_pkg
// Shared constants and types for the WUPR refresh scheduler slice.
//   ROW_WIDTH / N / N_BITS : WUPR geometry (row address width, segment count)
//   T_REFI                 : clock cycles per refresh interval
//   ROWS_PER_REF           : row-pointer stride per refresh slot (power of two)
//   MAX_DEBT / DEBT_W      : postponed-refresh ceiling and counter width
//   row_t, debt_t          : row address and debt counter types
//   ref_state_e            : scheduler FSM encoding
package wupr_pkg;

    localparam int ROW_WIDTH    = 16;
    localparam int N            = 16;
    localparam int N_BITS       = $clog2(N);
    localparam int T_REFI       = 3900;
    localparam int ROWS_PER_REF = 8;
    localparam int MAX_DEBT     = 8;
    localparam int DEBT_W       = $clog2(MAX_DEBT + 1);
    localparam int SKIP_W       = 16;

    typedef logic [ROW_WIDTH-1:0] row_t;
    typedef logic [DEBT_W-1:0]    debt_t;

    typedef enum logic [2:0] {
        IDLE,
        QUERY,
        CHECK,
        REQ,
        ADVANCE
    } ref_state_e;

endpackage

// File: rtl/wupr_refresh_scheduler_if.sv
// wupr_refresh_scheduler_if
// Bundles the write-update input, the WUPR query port, the refresh request
// handshake towards the command scheduler and the status/debug outputs.
//   master : the scheduler (drives WUPR port, ref_req/ref_row, status)
//   slave  : the environment (drives writes, dref verdict, ref_grant)
//
// Handshake: ref_req is the valid, ref_grant is the ready. ref_row is stable
// for as long as ref_req=1; the refresh transfers on the cycle where both are
// 1 and ref_req falls on the following cycle. ref_grant with ref_req=0 has no
// effect. wupr_dref answers a query one cycle after wupr_to_refresh=1.
interface wupr_refresh_scheduler_if
    import wupr_pkg::*;
();

    logic                wr_valid;
    row_t                wr_row;
    logic                wupr_rt_write;
    logic                wupr_to_refresh;
    row_t                wupr_ra;
    logic                wupr_dref;
    logic                ref_req;
    row_t                ref_row;
    logic                ref_grant;
    logic                ref_urgent;
    debt_t               debt;
    logic [SKIP_W-1:0]   skip_cnt;
    ref_state_e          dbg_state;
    logic                dbg_overflow;

    modport master (
        input  wr_valid, wr_row, wupr_dref, ref_grant,
        output wupr_rt_write, wupr_to_refresh, wupr_ra, ref_req, ref_row,
               ref_urgent, debt, skip_cnt, dbg_state, dbg_overflow
    );

    modport slave (
        output wr_valid, wr_row, wupr_dref, ref_grant,
        input  wupr_rt_write, wupr_to_refresh, wupr_ra, ref_req, ref_row,
               ref_urgent, debt, skip_cnt, dbg_state, dbg_overflow
    );

endinterface

// File: rtl/refi_timer.sv
// refi_timer
// Free-running refresh-interval counter, 0..T_REFI-1. tick is high for the
// single cycle the counter sits at T_REFI-1; the counter wraps on that edge.
//   clk  : clock
//   rst  : asynchronous active-high reset (counter to 0)
//   tick : one-cycle pulse once per T_REFI cycles
module refi_timer #(
    parameter int T_REFI = 3900
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(T_REFI - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wupr_refresh_scheduler.sv
// wupr_refresh_scheduler
// Turns tREFI ticks into refresh debt, walks a row pointer through the array
// and asks WUPR for each owed refresh whether it can be skipped as a dummy.
// Non-dummy refreshes are requested from the command scheduler. Row writes
// share the single WUPR Ra/Rt_write port and always win over queries.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wupr_refresh_scheduler_if.master (writes in, WUPR port out,
//              ref_req/ref_row/ref_grant handshake, debt/urgent/skip status,
//              FSM state and overflow flag for observation)
module wupr_refresh_scheduler
    import wupr_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    wupr_refresh_scheduler_if.master    bus
);

    localparam debt_t DEBT_MAX = debt_t'(MAX_DEBT);

    ref_state_e        state;
    ref_state_e        state_next;
    row_t              ptr;
    row_t              ref_row_r;
    debt_t             debt_r;
    debt_t             debt_next;
    logic [SKIP_W-1:0] skip_r;
    logic              overflow_sticky;
    logic              tick;
    logic              adv;
    logic              drop;

    refi_timer #(.T_REFI(T_REFI)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign adv = (state == ADVANCE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (debt_r != '0) state_next = QUERY;
            // A write owns the WUPR port this cycle; retry the query next cycle.
            QUERY:   if (!bus.wr_valid) state_next = CHECK;
            CHECK:   state_next = bus.wupr_dref ? ADVANCE : REQ;
            REQ:     if (bus.ref_grant) state_next = ADVANCE;
            ADVANCE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: WUPR port mux plus the request strobe
    always_comb begin
        bus.wupr_rt_write   = bus.wr_valid;
        bus.wupr_ra         = bus.wr_valid ? bus.wr_row : ptr;
        bus.wupr_to_refresh = (state == QUERY) && !bus.wr_valid;
        bus.ref_req         = (state == REQ);
    end

    // Debt bookkeeping: a tick and a retirement in the same cycle cancel out,
    // so saturation only matters for an unpaired tick.
    always_comb begin
        debt_next = debt_r;
        if (tick && !adv) begin
            if (debt_r != DEBT_MAX) debt_next = debt_r + debt_t'(1);
        end else if (adv && !tick) begin
            if (debt_r != '0) debt_next = debt_r - debt_t'(1);
        end
    end

    assign drop = tick && !adv && (debt_r == DEBT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr             <= '0;
            ref_row_r       <= '0;
            debt_r          <= '0;
            skip_r          <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            debt_r <= debt_next;
            if (drop) overflow_sticky <= 1'b1;
            if (adv) ptr <= ptr + row_t'(ROWS_PER_REF);
            if (state == CHECK) begin
                if (bus.wupr_dref) begin
                    if (skip_r != '1) skip_r <= skip_r + SKIP_W'(1);
                end else begin
                    ref_row_r <= ptr;
                end
            end
        end
    end

    assign bus.ref_row      = ref_row_r;
    assign bus.debt         = debt_r;
    assign bus.ref_urgent   = (debt_r == DEBT_MAX);
    assign bus.skip_cnt     = skip_r;
    assign bus.dbg_state    = state;
    assign bus.dbg_overflow = overflow_sticky;

endmodule

// File: tb/tb_wupr_refresh_scheduler.sv
// tb_wupr_refresh_scheduler
// Bench for wupr_refresh_scheduler: a WUPR responder/grant monitor running on
// the falling edge and a directed main sequence driving writes and reset.
module tb_wupr_refresh_scheduler;
    import wupr_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wupr_refresh_scheduler_if ifc ();

    wupr_refresh_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    // ---------------- scoreboard state ----------------
    logic [ROW_WIDTH-1:0] exp_q[$];
    row_t model_ptr;
    int   exp_skip;
    int   n_grants;
    int   n_checks;
    int   n_errors;
    bit   dref_plan;
    bit   grant_auto;
    bit   prev_query;
    bit   pend_dref;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_state(input ref_state_e st, input int budget, input string tag);
        int i = 0;
        while (ifc.dbg_state != st && i < budget) begin
            step();
            i++;
        end
        if (ifc.dbg_state != st) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timeout waiting for %s, state is %s", tag, st.name(), ifc.dbg_state.name());
        end
    endtask

    // ---------------- WUPR model + grant driver ----------------
    // Answers each query one cycle later with dref_plan and pushes the row a
    // real refresh must carry; grants pending requests when grant_auto=1.
    initial begin
        ifc.wupr_dref = 1'b0;
        ifc.ref_grant = 1'b0;
        prev_query    = 1'b0;
        pend_dref     = 1'b0;
        model_ptr     = '0;
        exp_skip      = 0;
        n_grants      = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_query    = 1'b0;
                ifc.wupr_dref = 1'b0;
                ifc.ref_grant = 1'b0;
                exp_q.delete();
                model_ptr     = '0;
                exp_skip      = 0;
            end else begin
                ifc.wupr_dref = prev_query ? pend_dref : 1'b0;
                prev_query    = ifc.wupr_to_refresh;
                if (ifc.wupr_to_refresh) begin
                    check_eq("query_ra", 32'(ifc.wupr_ra), 32'(model_ptr));
                    pend_dref = dref_plan;
                    if (dref_plan) exp_skip++;
                    else exp_q.push_back(model_ptr);
                    model_ptr = model_ptr + row_t'(ROWS_PER_REF);
                end
                ifc.ref_grant = 1'b0;
                if (ifc.ref_req && grant_auto) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL ref_req_unexpected: got ref_row 0x%0h with no refresh expected", ifc.ref_row);
                    end else begin
                        check_eq("ref_row", 32'(ifc.ref_row), 32'(exp_q.pop_front()));
                    end
                    ifc.ref_grant = 1'b1;
                    n_grants++;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int  turn;
        int  i;
        bit  saw_req;
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        ifc.wr_valid = 1'b0;
        ifc.wr_row   = '0;
        dref_plan    = 1'b0;
        grant_auto   = 1'b1;

        repeat (3) step();
        check_eq("rst_ref_req",  32'(ifc.ref_req), 32'(0));
        check_eq("rst_debt",     32'(ifc.debt), 32'(0));
        check_eq("rst_skip",     32'(ifc.skip_cnt), 32'(0));
        check_eq("rst_ra",       32'(ifc.wupr_ra), 32'(0));
        check_eq("rst_query",    32'(ifc.wupr_to_refresh), 32'(0));
        check_eq("rst_urgent",   32'(ifc.ref_urgent), 32'(0));
        check_eq("rst_ref_row",  32'(ifc.ref_row), 32'(0));
        check_eq("rst_state",    32'(ifc.dbg_state), 32'(IDLE));
        rst = 1'b0;

        // 1: first tick after T_REFI cycles, real refresh of row 0
        repeat (T_REFI - 1) step();
        check_eq("t1_debt_pre_tick", 32'(ifc.debt), 32'(0));
        step();
        check_eq("t1_debt_tick", 32'(ifc.debt), 32'(1));
        step();
        check_eq("t1_query", 32'(ifc.wupr_to_refresh), 32'(1));
        check_eq("t1_query_ra", 32'(ifc.wupr_ra), 32'(16'h0000));
        step();
        step();
        check_eq("t1_ref_req", 32'(ifc.ref_req), 32'(1));
        check_eq("t1_ref_row", 32'(ifc.ref_row), 32'(16'h0000));
        step();
        check_eq("t1_req_drop", 32'(ifc.ref_req), 32'(0));
        step();
        check_eq("t1_debt_done", 32'(ifc.debt), 32'(0));
        check_eq("t1_grants", 32'(n_grants), 32'(1));

        // 2: dummy refresh, 4-cycle IDLE to IDLE
        dref_plan = 1'b1;
        wait_state(QUERY, T_REFI + 10, "t2_wait_query");
        turn    = 1;
        saw_req = 1'b0;
        i       = 0;
        while (ifc.dbg_state != IDLE && i < 10) begin
            step();
            if (ifc.ref_req) saw_req = 1'b1;
            turn++;
            i++;
        end
        check_eq("t2_turnaround", 32'(turn), 32'(4));
        check_eq("t2_no_req", 32'(saw_req), 32'(0));
        check_eq("t2_skip_cnt", 32'(ifc.skip_cnt), 32'(exp_skip));
        check_eq("t2_skip_one", 32'(ifc.skip_cnt), 32'(1));
        check_eq("t2_debt", 32'(ifc.debt), 32'(0));

        // 3: writes block a pending query
        dref_plan = 1'b0;
        i = 0;
        while (!(ifc.dbg_state == IDLE && ifc.debt != '0) && i < T_REFI + 10) begin
            step();
            i++;
        end
        ifc.wr_valid = 1'b1;
        ifc.wr_row   = 16'h300A;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("t3_state_query", 32'(ifc.dbg_state), 32'(QUERY));
            check_eq("t3_rt_write", 32'(ifc.wupr_rt_write), 32'(1));
            check_eq("t3_ra_write", 32'(ifc.wupr_ra), 32'(16'h300A));
            check_eq("t3_no_query", 32'(ifc.wupr_to_refresh), 32'(0));
        end
        ifc.wr_valid = 1'b0;
        #1;
        check_eq("t3_query_resume", 32'(ifc.wupr_to_refresh), 32'(1));
        check_eq("t3_query_ra", 32'(ifc.wupr_ra), 32'(16'h0010));
        step();
        check_eq("t3_state_check", 32'(ifc.dbg_state), 32'(CHECK));
        wait_state(IDLE, 20, "t3_wait_idle");
        check_eq("t3_grants", 32'(n_grants), 32'(2));

        // 4: grant withheld, debt saturates, then drains
        grant_auto = 1'b0;
        wait_state(REQ, T_REFI + 10, "t4_wait_req");
        repeat (9 * T_REFI) step();
        check_eq("t4_debt_sat", 32'(ifc.debt), 32'(MAX_DEBT));
        check_eq("t4_urgent", 32'(ifc.ref_urgent), 32'(1));
        check_eq("t4_overflow", 32'(ifc.dbg_overflow), 32'(1));
        check_eq("t4_req_held", 32'(ifc.ref_req), 32'(1));
        check_eq("t4_row_held", 32'(ifc.ref_row), 32'(16'h0018));
        grant_auto = 1'b1;
        wait_state(ADVANCE, 5, "t4_wait_adv");
        step();
        check_eq("t4_debt_first_drain", 32'(ifc.debt), 32'(MAX_DEBT - 1));
        check_eq("t4_urgent_clear", 32'(ifc.ref_urgent), 32'(0));
        i = 0;
        while (!(ifc.debt == '0 && ifc.dbg_state == IDLE) && i < 200) begin
            step();
            i++;
        end
        check_eq("t4_drained", 32'(ifc.debt), 32'(0));
        check_eq("t4_grants", 32'(n_grants), 32'(10));

        // 5: row pointer wrap
        force dut.ptr = 16'hFFF8;
        step();
        release dut.ptr;
        model_ptr = 16'hFFF8;
        wait_state(QUERY, T_REFI + 10, "t5_wait_query");
        check_eq("t5_ra_top", 32'(ifc.wupr_ra), 32'(16'hFFF8));
        wait_state(IDLE, 20, "t5_wait_idle");
        check_eq("t5_grants", 32'(n_grants), 32'(11));
        grant_auto = 1'b0;
        wait_state(QUERY, T_REFI + 10, "t5_wait_query2");
        check_eq("t5_ptr_wrap", 32'(ifc.wupr_ra), 32'(16'h0000));

        // 6: reset while a request is outstanding
        wait_state(REQ, 5, "t6_wait_req");
        check_eq("t6_req_before", 32'(ifc.ref_req), 32'(1));
        #1;
        rst = 1'b1;
        #1;
        check_eq("t6_req_async", 32'(ifc.ref_req), 32'(0));
        check_eq("t6_state", 32'(ifc.dbg_state), 32'(IDLE));
        check_eq("t6_debt", 32'(ifc.debt), 32'(0));
        check_eq("t6_overflow", 32'(ifc.dbg_overflow), 32'(0));
        step();
        rst        = 1'b0;
        grant_auto = 1'b1;
        wait_state(QUERY, T_REFI + 10, "t6_wait_query");
        check_eq("t6_resume_ra", 32'(ifc.wupr_ra), 32'(16'h0000));
        wait_state(IDLE, 20, "t6_wait_idle");
        check_eq("t6_grants", 32'(n_grants), 32'(12));
        check_eq("t6_debt_done", 32'(ifc.debt), 32'(0));

        // final report
        check_eq("end_queue_empty", 32'(exp_q.size()), 32'(0));
        check_eq("end_skip_cnt", 32'(ifc.skip_cnt), 32'(exp_skip));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
